// File: rtl/gate_test_seq.sv
// gate_test_seq: self-test sequencer that sweeps a 2-input gate through all four
// input vectors and compares each sampled output against a latched truth table.
module gate_test_seq #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] truth_tbl,
    input  logic       y,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_mask,
    output logic [1:0] vec_idx
);
    localparam int CW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] SAMPLE = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    tbl_q, tbl_d;
    logic [1:0]    vec_q, vec_d;
    logic [3:0]    fail_q, fail_d;
    logic          pass_q, pass_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // done is registered so it lines up with busy falling and the final pass value
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tbl_d   = tbl_q;
        vec_d   = vec_q;
        fail_d  = fail_q;
        pass_d  = pass_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                tbl_d   = truth_tbl;
                vec_d   = 2'd0;
                cnt_d   = '0;
                fail_d  = 4'd0;
                pass_d  = 1'b0;
                busy_d  = 1'b1;
                state_d = SETTLE;
            end
            SETTLE: if (cnt_q == CNT_LAST) state_d = SAMPLE;
                    else cnt_d = cnt_q + CW'(1);
            SAMPLE: begin
                fail_d[vec_q] = (y != tbl_q[vec_q]);
                if (vec_q == 2'd3) state_d = DONE;
                else begin
                    vec_d   = vec_q + 2'd1;
                    cnt_d   = '0;
                    state_d = SETTLE;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                pass_d  = ~|fail_q;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tbl_q   <= 4'd0;
            vec_q   <= 2'd0;
            fail_q  <= 4'd0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tbl_q   <= tbl_d;
            vec_q   <= vec_d;
            fail_q  <= fail_d;
            pass_q  <= pass_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign a         = vec_q[1];
    assign b         = vec_q[0];
    assign vec_idx   = vec_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_mask = fail_q;
endmodule

// File: doc/gate_test_seq.md
# gate_test_seq

Self-test sequencer for a 2-input combinational gate under test (XNOR, AND, etc.). On a start request it drives the gate's `a`/`b` inputs through all four combinations, waits a programmable settle time for each, samples `y`, and compares it against a 4-bit expected truth table. At the end it reports a per-vector fail mask and a pass flag. It sits between a host/bench control interface and any single 2-input gate instance, so the same checker covers every gate block.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 2, is the number of cycles the DUT inputs are held before `y` is sampled. Legal range is 1 to 255.

Ports:
- `clk`, input, 1 bit: rising-edge clock.
- `rst_n`, input, 1 bit: asynchronous active-low reset.
- `start`, input, 1 bit: request a test run. Accepted only in IDLE.
- `truth_tbl`, input, 4 bits: expected `y`, indexed by `{a,b}`. Bit 0 is a=0,b=0 and bit 3 is a=1,b=1. Latched when `start` is accepted.
- `y`, input, 1 bit: output of the gate under test.
- `a`, output, 1 bit: gate input A (registered).
- `b`, output, 1 bit: gate input B (registered).
- `busy`, output, 1 bit: high from the accept edge until DONE is exited.
- `done`, output, 1 bit: one-cycle pulse at the end of a run.
- `pass`, output, 1 bit: sticky result, 1 when `fail_mask` is 0. Valid from `done` until the next accept.
- `fail_mask`, output, 4 bits: sticky. Bit i is set if `y` differed from `truth_tbl[i]` for vector i.
- `vec_idx`, output, 2 bits: index of the vector currently applied. Equals `{a,b}`.

## Operation
- FSM states: IDLE, SETTLE, SAMPLE, DONE. Encoding is free.
- IDLE:
  - If `start`=1, then on the same edge: `tbl_q` <= `truth_tbl`, `vec_idx` <= 0, `{a,b}` <= 2'b00, `cnt` <= 0, `fail_mask` <= 0, `pass` <= 0, `busy` <= 1, go to SETTLE.
  - If `start`=0, hold all outputs.
- SETTLE:
  - If `cnt` == SETTLE_CYCLES-1, go to SAMPLE.
  - Otherwise `cnt` <= `cnt`+1.
  - The state therefore lasts exactly SETTLE_CYCLES cycles.
- SAMPLE (one cycle):
  - `fail_mask[vec_idx]` <= (`y` != `tbl_q[vec_idx]`).
  - If `vec_idx` == 3, go to DONE.
  - Otherwise `vec_idx` <= `vec_idx`+1, `{a,b}` <= `vec_idx`+1, `cnt` <= 0, go to SETTLE.
- DONE (one cycle):
  - `done` = 1.
  - `pass` <= ~|`fail_mask`, using the fully updated mask.
  - `busy` <= 0, go to IDLE.
- `start` is ignored in SETTLE, SAMPLE and DONE. It is not queued.
- `truth_tbl` changes after the accept edge have no effect on the current run.
- `a`/`b` hold 2'b11 after a run completes, until the next accept.
- `cnt` width is $clog2(SETTLE_CYCLES+1), minimum 1. It never wraps within a run.
- `y` is sampled directly with no synchronizer. The gate under test is combinational from the registered `a`/`b`.

## Timing
- Reset values: `a`=0, `b`=0, `vec_idx`=0, `busy`=0, `done`=0, `pass`=0, `fail_mask`=0, state IDLE, `cnt`=0, `tbl_q`=0.
- Reset asserted mid-run aborts immediately, asynchronously. All outputs take their reset values. The run is not resumed after release.
- Label the accept edge E0. Then:
  - Vector i is applied after edge E0 + i·(S+1), where S = SETTLE_CYCLES.
  - Vector i is sampled at edge E0 + i·(S+1) + S + 1.
  - `y` is therefore stable for S+1 cycles before sampling.
- `done`, `busy`=0 and the final `pass` appear after edge E0 + 4·(S+1) + 1.
  - With S=2 that is edge E0+13, and the run occupies 13 cycles.
- `start` high in the cycle immediately after `done` (state IDLE) is accepted. Back-to-back runs therefore have a 1-cycle IDLE gap minimum.
- `start` held high continuously produces back-to-back runs, each separated by one IDLE cycle.

## Test plan
- **XNOR pass:** S=2, `y`=~(a^b), `truth_tbl`=4'b1001, pulse `start`. Required: `a`/`b` sequence 00,01,10,11, each held 3 cycles; `done` after E0+13; `pass`=1; `fail_mask`=4'b0000; `busy` high for exactly 13 cycles.
- **Wrong table:** XNOR DUT with `truth_tbl`=4'b1000 (AND). Required: `fail_mask`=4'b0001, `pass`=0.
- **Stuck-at-0 output:** `y` tied 0, `truth_tbl`=4'b1001. Required: `fail_mask`=4'b1001, `pass`=0. Results hold until the next `start`.
- **Busy protection:** pulse `start` at E0+4, and change `truth_tbl` to 4'b0000 at E0+1. Required: no restart, `done` is still after E0+13, and the result uses 4'b1001 (`pass`=1).
- **Reset mid-run:** assert `rst_n`=0 at E0+6 (vector 1 applied). Required: immediately `a`=`b`=0, `busy`=0, `fail_mask`=0, no `done`. A new `start` after release runs a full 13-cycle test.
- **Parameter/back-to-back:** S=1 with `start` held high. Required: `done` after E0+9, next accept 1 cycle later, and `fail_mask` cleared at each accept.
